stream_demux_1_n: RTL and testbench
===================================

// Module: stream_demux_1_n
// PURPOSE
//  Registered, parametrised 1-to-NUM_CH stream demultiplexer; next generation of our 1x2/1x8 gate demuxes.
//  Routes one valid/ready input stream to the channel given by in_sel; each channel has a 1-entry output buffer.
//  Sits between a single producer and NUM_CH independent consumers.
//  Out-of-range selects are dropped and flagged.
// PARAMETERS
//  WIDTH   8  data bits per beat (>=1)
//  NUM_CH  8  output channels (2..64, need not be a power of 2)
//  SEL_W   $clog2(NUM_CH)  select width (derived localparam, not overridable)
// PORTS
//  clk        in   1             single clock, all logic on rising edge
//  rst_n      in   1             synchronous, active-low reset
//  in_valid   in   1             input beat present
//  in_ready   out  1             input beat accepted when in_valid & in_ready
//  in_data    in   WIDTH         input payload
//  in_sel     in   SEL_W         destination channel
//  out_valid  out  NUM_CH        per-channel buffer full
//  out_ready  in   NUM_CH        per-channel consumer ready
//  out_data   out  NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  sel_err    out  1             1-cycle pulse: beat with in_sel>=NUM_CH was dropped
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all out_valid=0, out_data=0, sel_err=0; the beat presented in that cycle is not accepted.
//  Per channel i: full_i is the registered out_valid[i]; drain_i = full_i & out_ready[i].
//  in_ready = (in_sel>=NUM_CH) | ~full[in_sel] | drain[in_sel]; combinational from in_sel/out_ready, never from in_valid.
//  Accept to channel s: on the next edge out_valid[s]=1, out_data[s]=in_data. Latency 1 cycle; no data is ever visible combinationally.
//  Simultaneous drain+accept on the same channel: the buffer reloads, and out_valid stays 1 (full throughput, 1 beat/cycle/channel).
//  Drain without accept: out_valid[i]=0 next cycle; out_data holds its last value.
//  Held output: while out_valid[i]=1 & out_ready[i]=0, out_data[i] is stable.
//  Accepts to different channels in consecutive cycles are independent; a stalled channel never blocks others except by holding in_ready low when selected.
//  Invalid select (in_sel>=NUM_CH, only possible when NUM_CH is not 2^SEL_W): in_ready=1, beat discarded, sel_err=1 on the next cycle.
//  in_sel/in_data may change freely while in_valid=0; no stability requirement on the input side beyond the standard valid/ready rules.
// CONFIGURATION
//  STREAM_DEMUX_BCAST_EN defined: adds input port in_bcast (1 bit).
//    in_bcast=1 ignores in_sel and writes the beat to every channel.
//    in_ready = AND over i of (~full_i | drain_i); sel_err is never raised for a broadcast.
//    A partial broadcast is never performed.
//  Not defined: the port is absent; unicast only.
// STRUCTURE
//  Package stream_demux_pkg: MAX_CH=64 and a function ch_slice(idx) for WIDTH-slice indexing.
//  Sub-module stream_demux_slot: one channel's buffer (load, out_ready -> full, data), instantiated NUM_CH times by generate.
//  Top level: select decode, in_ready mux, broadcast logic, sel_err register.
// TESTING
//  Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_data=0, sel_err=0, and nothing is accepted.
//  Unicast: in_sel=3, in_data=8'hA5, all ready -> out_valid=8'h08 and out_data[31:24]=A5 the next cycle; cleared after one cycle.
//  Back-pressure: ch2 with out_ready[2]=0 and two beats to ch2 -> the 2nd sees in_ready=0 until out_ready[2]=1; then the beats arrive in order with no loss.
//  Stream: 16 beats to ch5, out_ready[5]=1 -> one beat per cycle, in_ready stays 1 throughout.
//  NUM_CH=6: in_sel=7 -> in_ready=1, no out_valid change, sel_err pulses exactly 1 cycle.
//  BCAST_EN: ch1 full and stalled, broadcast 8'h3C -> in_ready=0; release ch1 -> all 8 channels load 3C in the same cycle.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared constants and helpers for the stream_demux_1_n family.
package stream_demux_pkg;

    localparam int MAX_CH = 64;

    // Base bit position of channel idx inside a flat NUM_CH*width bus.
    function automatic int ch_slice(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One output channel of the demux: a single-entry buffer that reloads
// in the same cycle it drains so a channel can sustain one beat per cycle.
module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             full,
    output logic             drain,
    output logic [WIDTH-1:0] out_data
);

    logic             full_p1;
    logic [WIDTH-1:0] data_p1;

    // Stage p1: buffer register; load wins over drain so a same-cycle swap keeps full set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_p1 <= 1'b0;
            data_p1 <= '0;
        end else if (load) begin
            full_p1 <= 1'b1;
            data_p1 <= in_data;
        end else if (drain) begin
            full_p1 <= 1'b0;
        end
    end

    assign full     = full_p1;
    assign drain    = full_p1 & out_ready;
    assign out_data = data_p1;

endmodule

// File: rtl/stream_demux_1_n.sv
// Registered 1-to-NUM_CH valid/ready stream demultiplexer with per-channel buffers.
// Optional broadcast input enabled by defining STREAM_DEMUX_BCAST_EN.
module stream_demux_1_n
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
`ifdef STREAM_DEMUX_BCAST_EN
    input  logic                    in_bcast,
`endif
    output logic                    sel_err
);

    if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("stream_demux_1_n: NUM_CH must be within 2..64");
    end

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] drain;
    logic [NUM_CH-1:0] load;
    logic              bcast;
    logic              sel_ok;
    logic              accept;
    logic              sel_err_p1;

`ifdef STREAM_DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign sel_ok = ({1'b0, in_sel} < (SEL_W+1)'(NUM_CH));

    // Out-of-range selects are always ready so the producer can flush them.
    always_comb begin
        in_ready = 1'b1;
        if (bcast) begin
            in_ready = &(~full | drain);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_sel == SEL_W'(i)) begin
                    in_ready = ~full[i] | drain[i];
                end
            end
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = accept & (bcast | (in_sel == SEL_W'(i)));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        stream_demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[g]),
            .in_data   (in_data),
            .out_ready (out_ready[g]),
            .full      (full[g]),
            .drain     (drain[g]),
            .out_data  (out_data[ch_slice(g, WIDTH) +: WIDTH])
        );
    end

    assign out_valid = full;

    // Stage p1: flag a dropped unicast beat one cycle after it was taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_p1 <= 1'b0;
        end else begin
            sel_err_p1 <= accept & ~bcast & ~sel_ok;
        end
    end

    assign sel_err = sel_err_p1;

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Bench for stream_demux_1_n: directed + random traffic against a per-channel FIFO model.
module tb_stream_demux_1_n;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int N6 = 6;
    localparam int HD = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           in_valid, in_ready, in_bcast, sel_err;
    logic [W-1:0]   in_data;
    logic [2:0]     in_sel;
    logic [N-1:0]   out_valid, out_ready;
    logic [N*W-1:0] out_data;

    logic            v6, rdy6, err6;
    logic [W-1:0]    d6;
    logic [2:0]      sel6;
    logic [N6-1:0]   ov6, or6;
    logic [N6*W-1:0] od6;

    stream_demux_1_n #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef STREAM_DEMUX_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .sel_err   (sel_err)
    );

    stream_demux_1_n #(.WIDTH(W), .NUM_CH(N6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v6),
        .in_ready  (rdy6),
        .in_data   (d6),
        .in_sel    (sel6),
        .out_valid (ov6),
        .out_ready (or6),
        .out_data  (od6),
`ifdef STREAM_DEMUX_BCAST_EN
        .in_bcast  (1'b0),
`endif
        .sel_err   (err6)
    );

    int checks = 0;
    int errors = 0;

    // Model: each channel is a FIFO (hist/wr/rd) of accepted beats; lastv is the last beat written.
    logic [W-1:0] hist [N][HD];
    int           wr [N];
    int           rd [N];
    logic [W-1:0] lastv [N];
    bit           merr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        if (in_bcast) begin
            for (int c = 0; c < N; c++)
                if (wr[c] != rd[c] && !out_ready[c]) return 1'b0;
            return 1'b1;
        end
        if (int'(in_sel) >= N) return 1'b1;
        return (wr[in_sel] == rd[in_sel]) || out_ready[in_sel];
    endfunction

    // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs after it.
    task automatic cycle();
        logic [N-1:0]   ev;
        logic [N*W-1:0] ed;
        bit             acc;
        #3;
        if (rst_n) chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready()});
        acc = rst_n && in_valid && exp_ready();
        @(posedge clk);
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                wr[c] = 0; rd[c] = 0; lastv[c] = '0;
            end
            merr = 1'b0;
        end else begin
            for (int c = 0; c < N; c++)
                if (wr[c] != rd[c] && out_ready[c]) rd[c]++;
            if (acc) begin
                for (int c = 0; c < N; c++) begin
                    if (in_bcast || int'(in_sel) == c) begin
                        hist[c][wr[c] % HD] = in_data;
                        wr[c]++;
                        lastv[c] = in_data;
                    end
                end
            end
            merr = acc && !in_bcast && int'(in_sel) >= N;
        end
        #1;
        for (int c = 0; c < N; c++) begin
            ev[c] = (wr[c] != rd[c]);
            ed[c*W +: W] = ev[c] ? hist[c][rd[c] % HD] : lastv[c];
        end
        chk("out_valid", {56'd0, out_valid}, {56'd0, ev});
        chk("out_data", out_data, ed);
        chk("sel_err", {63'd0, sel_err}, {63'd0, merr});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 3'd3; in_data = 8'hEE;
        in_bcast = 1'b0; out_ready = '0;
        v6 = 1'b1; sel6 = 3'd1; d6 = 8'h99; or6 = '0;

        // Reset with a beat presented: nothing may be accepted.
        repeat (3) cycle();
        chk("rst_vld", {56'd0, out_valid}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_err", {63'd0, sel_err}, 64'd0);
        chk("rst_vld6", {58'd0, ov6}, 64'd0);

        rst_n = 1'b1; in_valid = 1'b0; v6 = 1'b0; or6 = '1;
        cycle();

        // Unicast to channel 3.
        in_valid = 1'b1; in_sel = 3'd3; in_data = 8'hA5; out_ready = '1;
        cycle();
        chk("uni_vld", {56'd0, out_valid}, 64'h08);
        chk("uni_data", {56'd0, out_data[31:24]}, 64'hA5);
        in_valid = 1'b0;
        cycle();
        chk("uni_clr", {56'd0, out_valid}, 64'h00);

        // Back-pressure on channel 2.
        out_ready = 8'hFB; in_valid = 1'b1; in_sel = 3'd2; in_data = 8'h11;
        cycle();
        in_data = 8'h22;
        #2 chk("bp_stall", {63'd0, in_ready}, 64'd0);
        cycle();
        cycle();
        chk("bp_hold", {56'd0, out_data[23:16]}, 64'h11);
        out_ready = '1;
        cycle();
        in_valid = 1'b0;
        chk("bp_second", {56'd0, out_data[23:16]}, 64'h22);
        cycle();
        chk("bp_empty", {56'd0, out_valid}, 64'h00);

        // Full-throughput stream to channel 5.
        in_valid = 1'b1; in_sel = 3'd5;
        for (int k = 0; k < 16; k++) begin
            in_data = W'($urandom);
            #1 chk("stream_rdy", {63'd0, in_ready}, 64'd1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();

        // Invalid select on the 6-channel instance.
        v6 = 1'b1; sel6 = 3'd7; d6 = 8'h77;
        #2 chk("n6_rdy", {63'd0, rdy6}, 64'd1);
        cycle();
        chk("n6_vld", {58'd0, ov6}, 64'd0);
        chk("n6_err", {63'd0, err6}, 64'd1);
        v6 = 1'b0;
        cycle();
        chk("n6_err_clr", {63'd0, err6}, 64'd0);
        v6 = 1'b1; sel6 = 3'd5; d6 = 8'h5A;
        cycle();
        chk("n6_uni_vld", {58'd0, ov6}, 64'h20);
        chk("n6_uni_data", {56'd0, od6[47:40]}, 64'h5A);
        chk("n6_uni_err", {63'd0, err6}, 64'd0);
        v6 = 1'b0;
        cycle();

`ifdef STREAM_DEMUX_BCAST_EN
        // Broadcast blocked by a stalled full channel, then released as a whole.
        out_ready = 8'hFD; in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h77;
        cycle();
        in_bcast = 1'b1; in_data = 8'h3C;
        #2 chk("bc_stall", {63'd0, in_ready}, 64'd0);
        cycle();
        chk("bc_partial", {56'd0, out_valid}, 64'h02);
        out_ready = '1;
        cycle();
        in_valid = 1'b0; in_bcast = 1'b0;
        chk("bc_vld", {56'd0, out_valid}, 64'hFF);
        for (int c = 0; c < N; c++)
            chk("bc_data", {56'd0, out_data[c*W +: W]}, 64'h3C);
        cycle();
`endif

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom);
            in_sel    = 3'($urandom);
            in_data   = W'($urandom);
            out_ready = N'($urandom);
`ifdef STREAM_DEMUX_BCAST_EN
            in_bcast  = ($urandom_range(0, 7) == 0);
`endif
            cycle();
        end
        in_valid = 1'b0; in_bcast = 1'b0; out_ready = '1;
        cycle();
        chk("final_empty", {56'd0, out_valid}, 64'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
